// File: rtl/ssp_tx_fifo_pkg.sv
// Shared SSP constants: FIFO geometry used by the transmit and receive paths.
package ssp_tx_fifo_pkg;
  localparam int SSP_DEPTH = 4;
  localparam int SSP_WIDTH = 8;
  localparam int SSP_PTR_W = $clog2(SSP_DEPTH);
endpackage

// File: rtl/ssp_fifo_ctrl.sv
// Circular-buffer bookkeeping: read/write pointers, occupancy and full/empty.
// Callers gate push/pop; this block only tracks them.
module ssp_fifo_ctrl
  import ssp_tx_fifo_pkg::*;
#(
  parameter int DEPTH = SSP_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [PTR_W:0]   o_count,
  output logic             o_full,
  output logic             o_empty
);
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
endmodule

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: bus writes enqueue, a transmit_complete rising edge
// dequeues the head word that the serial transmitter just finished sending.
module ssp_tx_fifo
  import ssp_tx_fifo_pkg::*;
#(
  parameter int DEPTH = SSP_DEPTH,
  parameter int WIDTH = SSP_WIDTH
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             PSEL,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] PWDATA,
  input  logic             transmit_complete,
  output logic [WIDTH-1:0] TxData,
  output logic             tx_ready,
  output logic             SSPTXINTR,
  output logic             tx_overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_tc_q;
  logic             r_intr;
  logic             r_ovf;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [PTR_W:0]   w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_req;
  logic             w_pop;
  logic             w_push;

  // Pop on the idle-going edge of the transmitter; a full FIFO still
  // accepts a write in that same cycle since a slot is being freed.
  assign w_wr_req = PSEL & PWRITE;
  assign w_pop    = transmit_complete & ~r_tc_q & ~w_empty;
  assign w_push   = w_wr_req & (~w_full | w_pop);

  ssp_fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ctrl (
    .clk      (PCLK),
    .rst_n    (CLEAR_B),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Storage is intentionally not reset; TxData is meaningless while empty.
  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[w_wr_ptr] <= PWDATA;
  end

  // Edge-detect history, free-space interrupt and sticky overflow.
  // tc_q resets high so a transmitter already idle at release cannot pop.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_tc_q <= 1'b1;
      r_intr <= 1'b1;
      r_ovf  <= 1'b0;
    end else begin
      r_tc_q <= transmit_complete;
      r_intr <= ~w_full;
      if (w_wr_req && !w_push) r_ovf <= 1'b1;
    end
  end

  // Hide the word being retired this cycle so it is never offered again.
  assign tx_ready    = ((w_count - {{PTR_W{1'b0}}, w_pop}) != '0);
  assign TxData      = r_mem[w_rd_ptr];
  assign SSPTXINTR   = r_intr;
  assign tx_overflow = r_ovf;
endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Directed bench for ssp_tx_fifo: accepted writes push the expected word into
// a scoreboard queue; a monitor retires it when the transmitter completes.
module tb_ssp_tx_fifo;
  logic       PCLK = 1'b0;
  logic       CLEAR_B = 1'b0;
  logic       PSEL = 1'b0;
  logic       PWRITE = 1'b0;
  logic [7:0] PWDATA = '0;
  logic       transmit_complete = 1'b1;
  logic [7:0] TxData;
  logic       tx_ready;
  logic       SSPTXINTR;
  logic       tx_overflow;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic       prev_tc = 1'b1;

  ssp_tx_fifo #(.DEPTH(4), .WIDTH(8)) dut (
    .PCLK              (PCLK),
    .CLEAR_B           (CLEAR_B),
    .PSEL              (PSEL),
    .PWRITE            (PWRITE),
    .PWDATA            (PWDATA),
    .transmit_complete (transmit_complete),
    .TxData            (TxData),
    .tx_ready          (tx_ready),
    .SSPTXINTR         (SSPTXINTR),
    .tx_overflow       (tx_overflow)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One-cycle write; acc says whether the hand analysis expects acceptance.
  task automatic wr(input logic [7:0] d, input bit acc);
    PSEL = 1'b1; PWRITE = 1'b1; PWDATA = d;
    if (acc) exp_q.push_back(d);
    tick();
    PSEL = 1'b0; PWRITE = 1'b0;
  endtask

  // Transmitter busy for n cycles, then goes idle (rising edge -> pop).
  task automatic frame(input int n);
    transmit_complete = 1'b0;
    repeat (n) tick();
    transmit_complete = 1'b1;
    tick();
  endtask

  // Monitor: on a transmit_complete rise the head word is retired; it must be
  // the oldest accepted word, and tx_ready must already exclude it.
  always @(negedge PCLK) begin
    if (!CLEAR_B) begin
      prev_tc = 1'b1;
    end else begin
      if (transmit_complete && !prev_tc) begin
        if (exp_q.size() != 0) begin
          chk("pop_data", {24'h0, TxData}, {24'h0, exp_q[0]});
          chk("pop_tx_ready", {31'h0, tx_ready}, (exp_q.size() > 1) ? 32'd1 : 32'd0);
          void'(exp_q.pop_front());
        end else begin
          chk("empty_rise_tx_ready", {31'h0, tx_ready}, 32'd0);
        end
      end
      prev_tc = transmit_complete;
    end
  end

  initial begin
    // Reset state
    @(negedge PCLK);
    chk("rst_tx_ready", {31'h0, tx_ready}, 32'd0);
    chk("rst_intr", {31'h0, SSPTXINTR}, 32'd1);
    chk("rst_ovf", {31'h0, tx_overflow}, 32'd0);
    @(posedge PCLK); #1;
    CLEAR_B = 1'b1;

    // Single word, one-cycle latency to tx_ready
    wr(8'hA5, 1);
    @(negedge PCLK);
    chk("a5_tx_ready", {31'h0, tx_ready}, 32'd1);
    chk("a5_data", {24'h0, TxData}, 32'hA5);
    chk("a5_intr", {31'h0, SSPTXINTR}, 32'd1);
    tick();
    frame(2);
    @(negedge PCLK);
    chk("a5_drained", {31'h0, tx_ready}, 32'd0);

    // Two words, long frame
    tick();
    wr(8'h11, 1);
    wr(8'h22, 1);
    frame(8);
    @(negedge PCLK);
    chk("after_pop_data", {24'h0, TxData}, 32'h22);
    chk("after_pop_ready", {31'h0, tx_ready}, 32'd1);
    tick();
    frame(3);

    // Single word: no resend after its frame
    wr(8'h3C, 1);
    frame(2);
    repeat (2) tick();
    @(negedge PCLK);
    chk("3c_no_resend", {31'h0, tx_ready}, 32'd0);
    tick();

    // Fill, then overflow write
    wr(8'h01, 1);
    wr(8'h02, 1);
    wr(8'h03, 1);
    wr(8'h04, 1);
    wr(8'hFF, 0);
    @(negedge PCLK);
    chk("ovf_set", {31'h0, tx_overflow}, 32'd1);
    chk("full_intr", {31'h0, SSPTXINTR}, 32'd0);
    chk("ovf_head", {24'h0, TxData}, 32'h01);
    chk("ovf_ready", {31'h0, tx_ready}, 32'd1);
    tick();

    // Write while full in the pop cycle
    transmit_complete = 1'b0;
    repeat (2) tick();
    transmit_complete = 1'b1;
    wr(8'h77, 1);
    tick();
    @(negedge PCLK);
    chk("still_full_intr", {31'h0, SSPTXINTR}, 32'd0);
    chk("still_full_head", {24'h0, TxData}, 32'h02);
    tick();
    repeat (4) frame(2);
    tick();
    @(negedge PCLK);
    chk("drained_intr", {31'h0, SSPTXINTR}, 32'd1);
    chk("drained_ready", {31'h0, tx_ready}, 32'd0);
    chk("ovf_sticky", {31'h0, tx_overflow}, 32'd1);
    tick();

    // Reset mid-frame
    wr(8'hAA, 1);
    wr(8'hBB, 1);
    wr(8'hCC, 1);
    transmit_complete = 1'b0;
    repeat (2) tick();
    CLEAR_B = 1'b0;
    exp_q.delete();
    @(negedge PCLK);
    chk("mid_rst_ready", {31'h0, tx_ready}, 32'd0);
    chk("mid_rst_ovf", {31'h0, tx_overflow}, 32'd0);
    chk("mid_rst_intr", {31'h0, SSPTXINTR}, 32'd1);
    tick();
    CLEAR_B = 1'b1;
    tick();
    transmit_complete = 1'b1;
    @(negedge PCLK);
    chk("rst_rise_ready", {31'h0, tx_ready}, 32'd0);
    tick();
    @(negedge PCLK);
    chk("rst_rise_nopop_ready", {31'h0, tx_ready}, 32'd0);
    chk("rst_rise_intr", {31'h0, SSPTXINTR}, 32'd1);
    tick();

    // First push accepted on the first edge after release
    CLEAR_B = 1'b0;
    tick();
    CLEAR_B = 1'b1;
    wr(8'h5A, 1);
    @(negedge PCLK);
    chk("release_ready", {31'h0, tx_ready}, 32'd1);
    chk("release_data", {24'h0, TxData}, 32'h5A);
    tick();
    frame(2);
    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
